nfc_status_responder: RTL and testbench

Target-side responder for the NAND Read Status (70h) and Read Status Enhanced (78h) sequences, acting as the device end of the status-polling path that the controller's command blocks issue. It oversamples asynchronous-mode NAND bus pins (CE#, CLE, ALE, WE#, RE#, DQ) in the system clock domain and decodes command and address cycles. It returns the selected LUN's live status byte on each RE# strobe. The block is synthesizable and serves as the status front end of the team's flash target model for loopback and controller verification.

---
 rtl/nfc_status_responder.sv | 177 +++++++++++++++++
 tb/tb_nfc_status_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/nfc_status_responder.sv
// Device-side responder for NAND Read Status (70h) and Read Status Enhanced (78h).
// Oversamples the async-mode bus pins and returns the addressed LUN's live status on each RE# strobe.
module nfc_status_responder #(
   parameter int NumberOfLUNs = 4,
   parameter int LUNShift     = 19
) (
   input  logic                      iSystemClock,
   input  logic                      iReset,
   input  logic                      iCE_n,
   input  logic                      iCLE,
   input  logic                      iALE,
   input  logic                      iWE_n,
   input  logic                      iRE_n,
   input  logic [7:0]                iDQ,
   input  logic [8*NumberOfLUNs-1:0] iLUNStatus,
   output logic [7:0]                oDQ,
   output logic                      oDQOutEnable,
   output logic [2:0]                oSelectedLUN,
   output logic [15:0]               oStatusReadCount
);

   typedef enum logic [1:0] {
      StIdle,
      StAddr,
      StStatus
   } state_t;

   localparam int PinCE  = 12;
   localparam int PinCLE = 11;
   localparam int PinALE = 10;
   localparam int PinWE  = 9;
   localparam int PinRE  = 8;

   localparam logic [12:0] PinsIdle = {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00};
   localparam logic [3:0]  NumLUNs  = 4'(NumberOfLUNs);

   logic [12:0] pinsMeta_q, pinsSync_q;
   logic        wePrev_q, rePrev_q;

   logic        ceHigh_q, cmdEvt_q, addrEvt_q, reFallEvt_q, reRiseEvt_q;
   logic [7:0]  evtByte_q;

   state_t      state_q;
   logic [1:0]  addrCount_q;
   logic [15:0] rowLow_q;
   logic [2:0]  servedLUN_q;
   logic        servedValid_q;
   logic [7:0]  dq_q;
   logic        oe_q;
   logic [2:0]  selLUN_q;
   logic [15:0] count_q;

   logic        weRise_d, reFall_d, reRise_d, latchOk_d;
   logic [23:0] rowFull_d;
   logic [2:0]  lunIdx_d;
   logic        lunIdxValid_d;
   logic [7:0]  liveStatus_d;
   logic [15:0] count_d;

   // Two-stage synchronizer plus a previous-value register on the strobes for edge detection.
   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) begin
         pinsMeta_q <= PinsIdle;
         pinsSync_q <= PinsIdle;
         wePrev_q   <= 1'b1;
         rePrev_q   <= 1'b1;
      end else begin
         pinsMeta_q <= {iCE_n, iCLE, iALE, iWE_n, iRE_n, iDQ};
         pinsSync_q <= pinsMeta_q;
         wePrev_q   <= pinsSync_q[PinWE];
         rePrev_q   <= pinsSync_q[PinRE];
      end
   end

   assign weRise_d  = pinsSync_q[PinWE] & ~wePrev_q;
   assign reFall_d  = ~pinsSync_q[PinRE] & rePrev_q;
   assign reRise_d  = pinsSync_q[PinRE] & ~rePrev_q;
   assign latchOk_d = weRise_d & ~pinsSync_q[PinCE];

   // Detected events are registered together with the DQ byte that was on the bus at the WE# edge.
   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) begin
         ceHigh_q    <= 1'b1;
         cmdEvt_q    <= 1'b0;
         addrEvt_q   <= 1'b0;
         reFallEvt_q <= 1'b0;
         reRiseEvt_q <= 1'b0;
         evtByte_q   <= 8'h00;
      end else begin
         ceHigh_q    <= pinsSync_q[PinCE];
         cmdEvt_q    <= latchOk_d & pinsSync_q[PinCLE] & ~pinsSync_q[PinALE];
         addrEvt_q   <= latchOk_d & pinsSync_q[PinALE] & ~pinsSync_q[PinCLE];
         reFallEvt_q <= reFall_d;
         reRiseEvt_q <= reRise_d;
         evtByte_q   <= pinsSync_q[7:0];
      end
   end

   assign rowFull_d     = {evtByte_q, rowLow_q};
   assign lunIdx_d      = 3'(rowFull_d >> LUNShift);
   assign lunIdxValid_d = ({1'b0, lunIdx_d} < NumLUNs);
   assign count_d       = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;

   always_comb begin
      liveStatus_d = 8'h00;
      if (servedValid_q) begin
         for (int k = 0; k < NumberOfLUNs; k++) begin
            if (servedLUN_q == 3'(k)) liveStatus_d = iLUNStatus[8*k +: 8];
         end
      end
   end

   // CE# high outranks everything, and a WE# event outranks a coincident RE# edge.
   always_ff @(posedge iSystemClock or posedge iReset) begin
      if (iReset) begin
         state_q       <= StIdle;
         addrCount_q   <= 2'd0;
         rowLow_q      <= 16'h0000;
         servedLUN_q   <= 3'd0;
         servedValid_q <= 1'b0;
         dq_q          <= 8'h00;
         oe_q          <= 1'b0;
         selLUN_q      <= 3'd0;
         count_q       <= 16'd0;
      end else if (ceHigh_q) begin
         state_q     <= StIdle;
         oe_q        <= 1'b0;
         addrCount_q <= 2'd0;
      end else if (cmdEvt_q) begin
         oe_q        <= 1'b0;
         addrCount_q <= 2'd0;
         if (evtByte_q == 8'h70) begin
            state_q       <= StStatus;
            servedLUN_q   <= selLUN_q;
            servedValid_q <= 1'b1;
         end else if (evtByte_q == 8'h78) begin
            state_q <= StAddr;
         end else begin
            state_q <= StIdle;
         end
      end else if (addrEvt_q && state_q == StAddr) begin
         case (addrCount_q)
            2'd0: begin
               rowLow_q[7:0] <= evtByte_q;
               addrCount_q   <= 2'd1;
            end
            2'd1: begin
               rowLow_q[15:8] <= evtByte_q;
               addrCount_q    <= 2'd2;
            end
            default: begin
               addrCount_q <= 2'd0;
               state_q     <= StStatus;
               servedLUN_q <= lunIdx_d;
               if (lunIdxValid_d) begin
                  selLUN_q      <= lunIdx_d;
                  servedValid_q <= 1'b1;
               end else begin
                  servedValid_q <= 1'b0;
               end
            end
         endcase
      end else if (state_q == StStatus && reFallEvt_q) begin
         dq_q    <= liveStatus_d;
         oe_q    <= 1'b1;
         count_q <= count_d;
      end else if (state_q == StStatus && reRiseEvt_q) begin
         oe_q <= 1'b0;
      end
   end

   assign oDQ              = dq_q;
   assign oDQOutEnable     = oe_q;
   assign oSelectedLUN     = selLUN_q;
   assign oStatusReadCount = count_q;

endmodule

// File: tb/tb_nfc_status_responder.sv
// Directed bench for nfc_status_responder: drives NAND bus cycles and checks status returns.
module tb_nfc_status_responder;

   logic        clk;
   logic        reset;
   logic        ceN, cle, ale, weN, reN;
   logic [7:0]  dqIn;
   logic [31:0] lunStatus;
   logic [7:0]  dqOut;
   logic        dqOe;
   logic [2:0]  selLUN;
   logic [15:0] readCount;

   int checks = 0;
   int errors = 0;

   nfc_status_responder #(
      .NumberOfLUNs(4),
      .LUNShift(19)
   ) dut (
      .iSystemClock    (clk),
      .iReset          (reset),
      .iCE_n           (ceN),
      .iCLE            (cle),
      .iALE            (ale),
      .iWE_n           (weN),
      .iRE_n           (reN),
      .iDQ             (dqIn),
      .iLUNStatus      (lunStatus),
      .oDQ             (dqOut),
      .oDQOutEnable    (dqOe),
      .oSelectedLUN    (selLUN),
      .oStatusReadCount(readCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic waitClocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic busWrite(input logic isCmd, input logic [7:0] value);
      cle  = isCmd;
      ale  = ~isCmd;
      dqIn = value;
      waitClocks(2);
      weN = 1'b0;
      waitClocks(3);
      weN = 1'b1;
      waitClocks(3);
      cle = 1'b0;
      ale = 1'b0;
      waitClocks(2);
   endtask

   task automatic reLow();
      reN = 1'b0;
      waitClocks(6);
   endtask

   task automatic reHigh();
      reN = 1'b1;
      waitClocks(6);
   endtask

   task automatic pulseReset();
      reset = 1'b1;
      waitClocks(2);
      reset = 1'b0;
      waitClocks(4);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      waitClocks(3);
      checks++; if (dqOut !== 8'h00) begin errors++; $display("[TB] FAIL reset_dq got %h want 00", dqOut); end
      checks++; if (dqOe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe got %b want 0", dqOe); end
      checks++; if (selLUN !== 3'd0) begin errors++; $display("[TB] FAIL reset_lun got %0d want 0", selLUN); end
      checks++; if (readCount !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", readCount); end
      reset = 1'b0;
      waitClocks(3);
   endtask

   task automatic test_read_status();
      lunStatus = {8'h00, 8'h00, 8'hC1, 8'hE0};
      ceN = 1'b0;
      waitClocks(6);
      busWrite(1'b1, 8'h70);
      checks++; if (dqOe !== 1'b0) begin errors++; $display("[TB] FAIL rs_oe_before_re got %b want 0", dqOe); end
      reLow();
      checks++; if (dqOut !== 8'hE0) begin errors++; $display("[TB] FAIL rs_dq got %h want e0", dqOut); end
      checks++; if (dqOe !== 1'b1) begin errors++; $display("[TB] FAIL rs_oe_low got %b want 1", dqOe); end
      reHigh();
      checks++; if (dqOe !== 1'b0) begin errors++; $display("[TB] FAIL rs_oe_high got %b want 0", dqOe); end
      checks++; if (dqOut !== 8'hE0) begin errors++; $display("[TB] FAIL rs_dq_hold got %h want e0", dqOut); end
      checks++; if (readCount !== 16'd1) begin errors++; $display("[TB] FAIL rs_count got %0d want 1", readCount); end
   endtask

   task automatic test_enhanced();
      busWrite(1'b1, 8'h78);
      busWrite(1'b0, 8'h00);
      busWrite(1'b0, 8'h00);
      busWrite(1'b0, 8'h08);
      reLow();
      checks++; if (dqOut !== 8'hC1) begin errors++; $display("[TB] FAIL enh_dq got %h want c1", dqOut); end
      checks++; if (selLUN !== 3'd1) begin errors++; $display("[TB] FAIL enh_lun got %0d want 1", selLUN); end
      reHigh();
      busWrite(1'b1, 8'h70);
      reLow();
      checks++; if (dqOut !== 8'hC1) begin errors++; $display("[TB] FAIL enh_70_dq got %h want c1", dqOut); end
      checks++; if (dqOe !== 1'b1) begin errors++; $display("[TB] FAIL enh_70_oe got %b want 1", dqOe); end
      reHigh();
      checks++; if (readCount !== 16'd3) begin errors++; $display("[TB] FAIL enh_count got %0d want 3", readCount); end
   endtask

   task automatic test_invalid_lun();
      busWrite(1'b1, 8'h78);
      busWrite(1'b0, 8'h00);
      busWrite(1'b0, 8'h00);
      busWrite(1'b0, 8'h28);
      reLow();
      checks++; if (dqOut !== 8'h00) begin errors++; $display("[TB] FAIL inv_dq got %h want 00", dqOut); end
      checks++; if (dqOe !== 1'b1) begin errors++; $display("[TB] FAIL inv_oe got %b want 1", dqOe); end
      checks++; if (selLUN !== 3'd1) begin errors++; $display("[TB] FAIL inv_lun got %0d want 1", selLUN); end
      reHigh();
      checks++; if (readCount !== 16'd4) begin errors++; $display("[TB] FAIL inv_count got %0d want 4", readCount); end
   endtask

   task automatic test_live_resample();
      pulseReset();
      lunStatus[7:0] = 8'h80;
      busWrite(1'b1, 8'h70);
      reLow();
      checks++; if (dqOut !== 8'h80) begin errors++; $display("[TB] FAIL live_first got %h want 80", dqOut); end
      reHigh();
      lunStatus[7:0] = 8'hE0;
      reLow();
      checks++; if (dqOut !== 8'hE0) begin errors++; $display("[TB] FAIL live_second got %h want e0", dqOut); end
      lunStatus[7:0] = 8'h55;
      waitClocks(6);
      checks++; if (dqOut !== 8'hE0) begin errors++; $display("[TB] FAIL live_hold_low got %h want e0", dqOut); end
      reHigh();
      checks++; if (readCount !== 16'd2) begin errors++; $display("[TB] FAIL live_count got %0d want 2", readCount); end
      lunStatus[7:0] = 8'hE0;
   endtask

   task automatic test_ce_abort();
      busWrite(1'b1, 8'h78);
      busWrite(1'b0, 8'h00);
      ceN = 1'b1;
      waitClocks(6);
      ceN = 1'b0;
      waitClocks(6);
      reLow();
      checks++; if (dqOe !== 1'b0) begin errors++; $display("[TB] FAIL abort_oe got %b want 0", dqOe); end
      reHigh();
      checks++; if (readCount !== 16'd2) begin errors++; $display("[TB] FAIL abort_count got %0d want 2", readCount); end
      busWrite(1'b1, 8'h78);
      busWrite(1'b0, 8'h00);
      busWrite(1'b1, 8'h70);
      reLow();
      checks++; if (dqOe !== 1'b1) begin errors++; $display("[TB] FAIL mid70_oe got %b want 1", dqOe); end
      checks++; if (dqOut !== 8'hE0) begin errors++; $display("[TB] FAIL mid70_dq got %h want e0", dqOut); end
      checks++; if (selLUN !== 3'd0) begin errors++; $display("[TB] FAIL mid70_lun got %0d want 0", selLUN); end
      reHigh();
   endtask

   task automatic test_async_reset();
      busWrite(1'b1, 8'h78);
      busWrite(1'b0, 8'h00);
      busWrite(1'b0, 8'h00);
      busWrite(1'b0, 8'h08);
      reLow();
      checks++; if (dqOe !== 1'b1 || dqOut !== 8'hC1) begin errors++; $display("[TB] FAIL ar_pre got oe=%b dq=%h want oe=1 dq=c1", dqOe, dqOut); end
      #3 reset = 1'b1;
      #1;
      checks++; if (dqOe !== 1'b0) begin errors++; $display("[TB] FAIL ar_oe got %b want 0", dqOe); end
      checks++; if (dqOut !== 8'h00) begin errors++; $display("[TB] FAIL ar_dq got %h want 00", dqOut); end
      checks++; if (readCount !== 16'd0) begin errors++; $display("[TB] FAIL ar_count got %0d want 0", readCount); end
      checks++; if (selLUN !== 3'd0) begin errors++; $display("[TB] FAIL ar_lun got %0d want 0", selLUN); end
      @(negedge clk);
      reset = 1'b0;
      reN = 1'b1;
      waitClocks(8);
      checks++; if (dqOe !== 1'b0) begin errors++; $display("[TB] FAIL ar_idle_oe got %b want 0", dqOe); end
   endtask

   initial begin
      reset     = 1'b1;
      ceN       = 1'b1;
      cle       = 1'b0;
      ale       = 1'b0;
      weN       = 1'b1;
      reN       = 1'b1;
      dqIn      = 8'h00;
      lunStatus = 32'h0;
      test_reset();
      test_read_status();
      test_enhanced();
      test_invalid_lun();
      test_live_resample();
      test_ce_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
